// File: rtl/battle_pkg.sv
// Shared types and constants for the battle screen: phase codes seen by the
// menu / player-attack / enemy-attack renderers, and the HP arithmetic helper.
package battle_pkg;

  localparam int PHASE_BITS  = 4;
  localparam int HP_W        = 8;
  localparam int FRAME_CNT_W = 11;

  typedef enum logic [PHASE_BITS-1:0] {
    PH_IDLE   = 4'b0000,
    PH_ATTACK = 4'b0001,
    PH_ENEMY  = 4'b0010,
    PH_MENU   = 4'b0011,
    PH_WIN    = 4'b1000,
    PH_LOSE   = 4'b1001
  } phase_t;

  // Bit positions of each renderer's done pulse in finished_in.
  localparam int FIN_MENU   = 0;
  localparam int FIN_ATTACK = 1;
  localparam int FIN_ENEMY  = 2;

  // Widen by one bit so the borrow shows up, then clamp to zero on underflow.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    logic [HP_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[HP_W] ? '0 : diff[HP_W-1:0];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts frame ticks (raster at 0,0) while enabled; clear has priority,
// the count saturates, and hit_o flags that the limit has been reached.
module frame_timer #(
  parameter int CNT_W = 11,
  parameter int LIMIT = 1800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_i,
  input  logic [9:0]       vcount_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             frame_tick;

  assign frame_tick = (hcount_i == 11'd0) && (vcount_i == 10'd0);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && frame_tick && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/battle_sequencer.sv
// Battle turn scheduler: steps MENU -> ATTACK -> ENEMY, applies damage, counts
// turns and force-advances a phase whose renderer never reports done.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int PLAYER_HP_INIT = 92,
  parameter int ENEMY_HP_INIT  = 192,
  parameter int TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic [2:0]  finished_in,
  input  logic [7:0]  enemy_dmg_in,
  input  logic [7:0]  player_dmg_in,
  output logic [3:0]  state_out,
  output logic [7:0]  enemy_hp_out,
  output logic [7:0]  player_hp_out,
  output logic [7:0]  turn_out,
  output logic        timeout_out
);

  phase_t          state_q, state_d;
  logic [HP_W-1:0] enemy_hp_q, enemy_hp_d;
  logic [HP_W-1:0] player_hp_q, player_hp_d;
  logic [7:0]      turn_q, turn_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      age_q, age_d;

  logic            enter;
  logic            armed;
  logic            active;
  logic            hit;
  logic            done;
  logic [HP_W-1:0] dmg;
  logic [HP_W-1:0] hp_new;

  // A done pulse only counts two cycles after phase entry, so the previous
  // renderer's pulse that is still dropping cannot skip the new phase.
  assign armed  = (age_q == 2'd2);
  assign active = (state_q == PH_MENU) || (state_q == PH_ATTACK) || (state_q == PH_ENEMY);

  frame_timer #(
    .CNT_W (FRAME_CNT_W),
    .LIMIT (TIMEOUT_FRAMES)
  ) u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .clear_i  (enter),
    .enable_i (active),
    .hit_o    (hit)
  );

  always_comb begin
    state_d     = state_q;
    enemy_hp_d  = enemy_hp_q;
    player_hp_d = player_hp_q;
    turn_d      = turn_q;
    timeout_d   = 1'b0;
    enter       = 1'b0;
    done        = 1'b0;
    dmg         = '0;
    hp_new      = '0;

    case (state_q)
      PH_IDLE, PH_WIN, PH_LOSE: begin
        if (start_in) begin
          state_d     = PH_MENU;
          enemy_hp_d  = HP_W'(ENEMY_HP_INIT);
          player_hp_d = HP_W'(PLAYER_HP_INIT);
          turn_d      = '0;
          enter       = 1'b1;
        end
      end
      PH_MENU: begin
        done = armed && finished_in[FIN_MENU];
        if (done || hit) begin
          state_d   = PH_ATTACK;
          timeout_d = !done;
          enter     = 1'b1;
        end
      end
      PH_ATTACK: begin
        done = armed && finished_in[FIN_ATTACK];
        if (done || hit) begin
          dmg        = done ? enemy_dmg_in : '0;
          hp_new     = sat_sub(enemy_hp_q, dmg);
          enemy_hp_d = hp_new;
          state_d    = (hp_new == '0) ? PH_WIN : PH_ENEMY;
          timeout_d  = !done;
          enter      = 1'b1;
        end
      end
      PH_ENEMY: begin
        done = armed && finished_in[FIN_ENEMY];
        if (done || hit) begin
          dmg         = done ? player_dmg_in : '0;
          hp_new      = sat_sub(player_hp_q, dmg);
          player_hp_d = hp_new;
          turn_d      = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
          state_d     = (hp_new == '0) ? PH_LOSE : PH_MENU;
          timeout_d   = !done;
          enter       = 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
        enter   = 1'b1;
      end
    endcase

    age_d = enter ? 2'd0 : ((age_q == 2'd2) ? age_q : age_q + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PH_IDLE;
      enemy_hp_q  <= HP_W'(ENEMY_HP_INIT);
      player_hp_q <= HP_W'(PLAYER_HP_INIT);
      turn_q      <= '0;
      timeout_q   <= 1'b0;
      age_q       <= '0;
    end else begin
      state_q     <= state_d;
      enemy_hp_q  <= enemy_hp_d;
      player_hp_q <= player_hp_d;
      turn_q      <= turn_d;
      timeout_q   <= timeout_d;
      age_q       <= age_d;
    end
  end

  assign state_out     = state_q;
  assign enemy_hp_out  = enemy_hp_q;
  assign player_hp_out = player_hp_q;
  assign turn_out      = turn_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: phase flow, arming, damage clamping,
// frame timeout (with and without a coincident done) and mid-phase reset.
module tb_battle_sequencer;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic [2:0]  finished_in;
  logic [7:0]  enemy_dmg_in;
  logic [7:0]  player_dmg_in;
  logic [3:0]  state_out;
  logic [7:0]  enemy_hp_out;
  logic [7:0]  player_hp_out;
  logic [7:0]  turn_out;
  logic        timeout_out;

  int checks   = 0;
  int failures = 0;

  battle_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .start_in      (start_in),
    .finished_in   (finished_in),
    .enemy_dmg_in  (enemy_dmg_in),
    .player_dmg_in (player_dmg_in),
    .state_out     (state_out),
    .enemy_hp_out  (enemy_hp_out),
    .player_hp_out (player_hp_out),
    .turn_out      (turn_out),
    .timeout_out   (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] f,
                               input logic [7:0] ed, input logic [7:0] pd);
    start_in      = s;
    finished_in   = f;
    enemy_dmg_in  = ed;
    player_dmg_in = pd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Each loop pass has one cycle without and one cycle with a frame tick.
  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      hcount_in = 11'd5;
      tick();
      hcount_in = 11'd0;
      tick();
    end
    hcount_in = 11'd5;
  endtask

  initial begin
    hcount_in = 11'd5;
    vcount_in = 10'd0;
    rst       = 1'b1;
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_state", 32'(state_out), 32'd0);
    checkOutput("reset_enemy_hp", 32'(enemy_hp_out), 32'd192);
    checkOutput("reset_player_hp", 32'(player_hp_out), 32'd92);
    checkOutput("reset_turn", 32'(turn_out), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_out), 32'd0);

    applyStimulus(1'b1, 3'b000, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("start_state", 32'(state_out), 32'd3);
    checkOutput("start_player_hp", 32'(player_hp_out), 32'd92);
    checkOutput("start_enemy_hp", 32'(enemy_hp_out), 32'd192);
    checkOutput("start_turn", 32'(turn_out), 32'd0);

    tick();
    tick();
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    checkOutput("menu_done_state", 32'(state_out), 32'd1);

    applyStimulus(1'b0, 3'b011, 8'd0, 8'd0);
    tick();
    checkOutput("unarmed_entry_state", 32'(state_out), 32'd1);
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    checkOutput("stale_menu_state", 32'(state_out), 32'd1);
    applyStimulus(1'b0, 3'b010, 8'd24, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("attack_done_state", 32'(state_out), 32'd2);
    checkOutput("attack_enemy_hp", 32'(enemy_hp_out), 32'd168);

    frameTicks(1800);
    checkOutput("pre_timeout_state", 32'(state_out), 32'd2);
    checkOutput("pre_timeout_pulse", 32'(timeout_out), 32'd0);
    tick();
    checkOutput("timeout_state", 32'(state_out), 32'd3);
    checkOutput("timeout_pulse", 32'(timeout_out), 32'd1);
    checkOutput("timeout_player_hp", 32'(player_hp_out), 32'd92);
    checkOutput("timeout_enemy_hp", 32'(enemy_hp_out), 32'd168);
    checkOutput("timeout_turn", 32'(turn_out), 32'd1);
    tick();
    checkOutput("timeout_pulse_end", 32'(timeout_out), 32'd0);

    tick();
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    checkOutput("menu2_state", 32'(state_out), 32'd1);
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    tick();
    tick();
    applyStimulus(1'b0, 3'b010, 8'd158, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("attack2_state", 32'(state_out), 32'd2);
    checkOutput("attack2_enemy_hp", 32'(enemy_hp_out), 32'd10);

    frameTicks(1800);
    applyStimulus(1'b0, 3'b100, 8'd0, 8'd30);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("hit_done_state", 32'(state_out), 32'd3);
    checkOutput("hit_done_pulse", 32'(timeout_out), 32'd0);
    checkOutput("hit_done_player_hp", 32'(player_hp_out), 32'd62);
    checkOutput("hit_done_turn", 32'(turn_out), 32'd2);
    tick();
    checkOutput("hit_done_pulse_after", 32'(timeout_out), 32'd0);

    tick();
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    tick();
    tick();
    applyStimulus(1'b0, 3'b010, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("zero_dmg_state", 32'(state_out), 32'd2);
    checkOutput("zero_dmg_enemy_hp", 32'(enemy_hp_out), 32'd10);
    tick();
    tick();
    applyStimulus(1'b0, 3'b100, 8'd0, 8'd100);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("lose_state", 32'(state_out), 32'd9);
    checkOutput("lose_player_hp", 32'(player_hp_out), 32'd0);
    checkOutput("lose_turn", 32'(turn_out), 32'd3);

    tick();
    applyStimulus(1'b1, 3'b000, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("restart_state", 32'(state_out), 32'd3);
    checkOutput("restart_player_hp", 32'(player_hp_out), 32'd92);
    checkOutput("restart_enemy_hp", 32'(enemy_hp_out), 32'd192);
    checkOutput("restart_turn", 32'(turn_out), 32'd0);

    tick();
    tick();
    applyStimulus(1'b1, 3'b110, 8'd50, 8'd50);
    tick();
    checkOutput("mismatch_state", 32'(state_out), 32'd3);
    checkOutput("mismatch_enemy_hp", 32'(enemy_hp_out), 32'd192);
    checkOutput("mismatch_player_hp", 32'(player_hp_out), 32'd92);
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("menu3_state", 32'(state_out), 32'd1);
    tick();
    tick();
    applyStimulus(1'b0, 3'b010, 8'd200, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("win_state", 32'(state_out), 32'd8);
    checkOutput("win_enemy_hp", 32'(enemy_hp_out), 32'd0);

    applyStimulus(1'b1, 3'b000, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("win_restart_state", 32'(state_out), 32'd3);
    checkOutput("win_restart_enemy_hp", 32'(enemy_hp_out), 32'd192);
    tick();
    tick();
    applyStimulus(1'b0, 3'b001, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    tick();
    tick();
    applyStimulus(1'b0, 3'b010, 8'd182, 8'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("pre_rst_state", 32'(state_out), 32'd2);
    checkOutput("pre_rst_enemy_hp", 32'(enemy_hp_out), 32'd10);

    tick();
    tick();
    applyStimulus(1'b0, 3'b100, 8'd0, 8'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 3'b000, 8'd0, 8'd0);
    checkOutput("mid_rst_state", 32'(state_out), 32'd0);
    checkOutput("mid_rst_player_hp", 32'(player_hp_out), 32'd92);
    checkOutput("mid_rst_enemy_hp", 32'(enemy_hp_out), 32'd192);
    checkOutput("mid_rst_turn", 32'(turn_out), 32'd0);
    checkOutput("mid_rst_timeout", 32'(timeout_out), 32'd0);
    tick();
    checkOutput("post_rst_state", 32'(state_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
